// File: rtl/bmp_pixel_packer_if.sv
// bmp_pixel_packer_if: SD byte stream into the packer and its frame-buffer write port out
interface bmp_pixel_packer_if;
    logic        sd_data_valid;
    logic [7:0]  sd_data;
    logic        write_req;
    logic        write_req_ack;
    logic        write_en;
    logic [31:0] write_data;
    modport master (
        input  sd_data_valid, sd_data, write_req_ack,
        output write_req, write_en, write_data
    );
    modport slave (
        output sd_data_valid, sd_data, write_req_ack,
        input  write_req, write_en, write_data
    );
endinterface

// File: rtl/bmp_pixel_packer.sv
// bmp_pixel_packer: skips the BMP header and packs file bytes little-endian into 32-bit frame-buffer words
module bmp_pixel_packer #(
    parameter int HDR_BYTES   = 54,
    parameter int FRAME_WORDS = 307200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    bmp_pixel_packer_if.master bus,
    output logic               busy,
    output logic               frame_done,
    output logic               drop_err
);
    typedef enum logic [1:0] {IDLE, REQ, PACK, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  hdr_cnt_q, hdr_cnt_d;
    logic [23:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] lanes_q, lanes_d;
    logic [31:0] write_data_q, write_data_d;
    logic        write_req_q, write_req_d;
    logic        write_en_q, write_en_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        drop_err_q, drop_err_d;
    logic        active, hdr_done, pix;
    always_comb begin
        active       = state_q == REQ || state_q == PACK;
        hdr_done     = hdr_cnt_q == 8'(HDR_BYTES);
        pix          = active && bus.sd_data_valid && hdr_done;
        state_d      = state_q;
        hdr_cnt_d    = (active && bus.sd_data_valid && !hdr_done) ? hdr_cnt_q + 8'd1 : hdr_cnt_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        lanes_d      = lanes_q;
        write_data_d = write_data_q;
        write_req_d  = write_req_q;
        write_en_d   = 1'b0;
        drop_err_d   = drop_err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = REQ;
                write_req_d = 1'b1;
                hdr_cnt_d   = '0;
                word_cnt_d  = '0;
                byte_idx_d  = '0;
                drop_err_d  = 1'b0;
            end
            REQ: begin
                // pixel bytes before the acknowledge have nowhere to go
                drop_err_d  = drop_err_q | pix;
                write_req_d = !bus.write_req_ack;
                state_d     = bus.write_req_ack ? PACK : REQ;
            end
            PACK: if (pix) begin
                lanes_d    = {bus.sd_data, lanes_q[23:8]};
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    write_en_d   = 1'b1;
                    write_data_d = {bus.sd_data, lanes_q};
                    word_cnt_d   = word_cnt_q + 24'd1;
                    state_d      = (word_cnt_d == 24'(FRAME_WORDS)) ? DONE : PACK;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d       = state_d != IDLE;
        frame_done_d = state_q == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hdr_cnt_q    <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            lanes_q      <= '0;
            write_data_q <= '0;
            write_req_q  <= 1'b0;
            write_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            lanes_q      <= lanes_d;
            write_data_q <= write_data_d;
            write_req_q  <= write_req_d;
            write_en_q   <= write_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
        end
    end
    assign bus.write_req  = write_req_q;
    assign bus.write_en   = write_en_q;
    assign bus.write_data = write_data_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign drop_err       = drop_err_q;
endmodule

// File: tb/tb_bmp_pixel_packer.sv
// tb_bmp_pixel_packer: three packer configurations driven by directed and random frames against a byte-list model
module tb_bmp_pixel_packer;
    localparam int H0 = 2, F0 = 2, H1 = 54, F1 = 12, H2 = 0, F2 = 1;
    logic        clk = 1'b0;
    logic        rn   [3];
    logic        st   [3];
    logic        vld  [3];
    logic        ack  [3];
    logic [7:0]  dat  [3];
    logic        wreq [3];
    logic        wen  [3];
    logic [31:0] wd   [3];
    logic        busy [3];
    logic        fd   [3];
    logic        de   [3];
    int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0, cur = 0;
    logic [31:0] got_w [$];
    int          got_t [$];
    int          fd_t  [$];
    logic [7:0]  fixed_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bmp_pixel_packer_if bus ();
        assign bus.sd_data_valid = vld[g];
        assign bus.sd_data       = dat[g];
        assign bus.write_req_ack = ack[g];
        assign wreq[g]           = bus.write_req;
        assign wen[g]            = bus.write_en;
        assign wd[g]             = bus.write_data;
        bmp_pixel_packer #(
            .HDR_BYTES  (g == 0 ? H0 : g == 1 ? H1 : H2),
            .FRAME_WORDS(g == 0 ? F0 : g == 1 ? F1 : F2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rn[g]),
            .start     (st[g]),
            .bus       (bus),
            .busy      (busy[g]),
            .frame_done(fd[g]),
            .drop_err  (de[g])
        );
    end

    function automatic int hdr_of(input int k);
        return k == 0 ? H0 : k == 1 ? H1 : H2;
    endfunction

    function automatic int fw_of(input int k);
        return k == 0 ? F0 : k == 1 ? F1 : F2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wen[cur]) begin
            got_w.push_back(wd[cur]);
            got_t.push_back(cyc);
        end
        if (fd[cur]) fd_t.push_back(cyc);
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, "_write_req"}, wreq[k], 0);
        chk({tag, "_write_en"}, wen[k], 0);
        chk({tag, "_write_data"}, wd[k], 0);
        chk({tag, "_busy"}, busy[k], 0);
        chk({tag, "_frame_done"}, fd[k], 0);
        chk({tag, "_drop_err"}, de[k], 0);
    endtask

    // Bytes are scheduled on relative cycles; the model only needs to know whether each byte
    // arrived before/at the ack (still requesting) or after it (packing).
    task automatic frame(input int k, input int ack_dly, input int n_early, input int n_bytes,
                         input int restart_at, input bit gaps);
        int h = hdr_of(k);
        int fw = fw_of(k);
        logic [7:0] b [$];
        int bc [$];
        logic [31:0] ew [$];
        int et [$];
        int hdr = 0, lane = 0, nw = 0, c = 0, j = 0, s, last;
        bit drop = 1'b0;
        logic [31:0] acc = '0;
        for (int i = 0; i < n_bytes; i++) begin
            if (i == n_early && c <= ack_dly) c = ack_dly + 1;
            if (gaps) c += int'($urandom_range(0, 1));
            b.push_back(i < fixed_q.size() ? fixed_q[i] : 8'($urandom));
            bc.push_back(c);
            c++;
        end
        for (int i = 0; i < n_bytes; i++) begin
            if (hdr < h) hdr++;
            else if (bc[i] <= ack_dly) drop = 1'b1;
            else if (nw < fw) begin
                acc[8*lane +: 8] = b[i];
                if (lane == 3) begin
                    ew.push_back(acc);
                    et.push_back(bc[i] + 1);
                    nw++;
                end
                lane = (lane + 1) % 4;
            end
        end
        cur = k;
        got_w.delete();
        got_t.delete();
        fd_t.delete();
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
        s = cyc;
        chk("busy_on_start", busy[k], 1);
        chk("req_on_start", wreq[k], 1);
        chk("drop_cleared_on_start", de[k], 0);
        last = ack_dly;
        if (n_bytes > 0 && bc[n_bytes-1] > last) last = bc[n_bytes-1];
        last += 4;
        for (c = 0; c <= last; c++) begin
            ack[k] = c == ack_dly;
            st[k]  = c == restart_at;
            vld[k] = j < n_bytes && bc[j] == c;
            dat[k] = vld[k] ? b[j] : 8'($urandom);
            if (vld[k]) j++;
            tick();
            if (c == ack_dly - 1 || c == ack_dly) chk("write_req", wreq[k], c < ack_dly);
        end
        ack[k] = 1'b0;
        st[k]  = 1'b0;
        vld[k] = 1'b0;
        chk("word_count", got_w.size(), ew.size());
        for (int i = 0; i < ew.size() && i < got_w.size(); i++) begin
            chk("word_data", got_w[i], ew[i]);
            chk("word_cycle", got_t[i], s + et[i]);
        end
        chk("frame_done_count", fd_t.size(), nw == fw);
        if (nw == fw && fd_t.size() > 0) chk("frame_done_cycle", fd_t[0], s + et[nw-1] + 1);
        chk("busy_end", busy[k], nw < fw);
        chk("drop_err_end", de[k], drop);
        if (nw > 0) chk("data_hold", wd[k], ew[nw-1]);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rn[k] = 1'b1; st[k] = 1'b0; vld[k] = 1'b0; ack[k] = 1'b0; dat[k] = '0;
        end
        #2;
        for (int k = 0; k < 3; k++) rn[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk_zero(k, "reset");
        #10;
        for (int k = 0; k < 3; k++) rn[k] = 1'b1;
        tick();

        fixed_q = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        frame(0, 0, 0, 10, -1, 1'b0);
        fixed_q.delete();
        chk("hdr2_word0", got_w.size() > 0 ? got_w[0] : '0, 32'h04030201);
        chk("hdr2_word1", got_w.size() > 1 ? got_w[1] : '0, 32'h08070605);

        fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        frame(2, 0, 0, 5, -1, 1'b0);
        fixed_q.delete();
        chk("hdr0_word", got_w.size() > 0 ? got_w[0] : '0, 32'h44332211);
        chk("hdr0_no_drop", de[2], 0);

        frame(1, 100, 60, 60 + 48, -1, 1'b0);
        chk("early_bytes_drop", de[1], 1);

        frame(1, 5, 0, H1 + 4*F1 + 4, 25, 1'b1);
        chk("restart_ignored_words", got_w.size(), F1);

        for (int r = 0; r < 4; r++) begin
            int e = int'($urandom_range(0, 70));
            frame(1, int'($urandom_range(0, 20)), e, e + H1 + 4*F1 + int'($urandom_range(0, 8)), -1, 1'b1);
        end
        for (int r = 0; r < 4; r++) begin
            int e = int'($urandom_range(0, 5));
            frame(0, int'($urandom_range(0, 4)), e, e + H0 + 4*F0 + int'($urandom_range(0, 3)), -1, 1'b1);
        end

        frame(1, 3, 0, H1 + 40, -1, 1'b1);
        rn[1] = 1'b0;
        #1;
        chk_zero(1, "reset_mid_frame");
        got_w.delete();
        fd_t.delete();
        for (int i = 0; i < 12; i++) begin
            vld[1] = 1'b1;
            dat[1] = 8'($urandom);
            if (i == 6) rn[1] = 1'b1;
            tick();
        end
        vld[1] = 1'b0;
        chk("no_write_after_reset", got_w.size(), 0);
        chk("idle_bytes_no_drop", de[1], 0);
        chk("idle_not_busy", busy[1], 0);
        frame(1, 2, 0, H1 + 4*F1, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
